// File: rtl/matvec_pkg.sv
// Shared types and helpers for the matrix-vector engine: FSM state encoding,
// default geometry, and MS-first element extraction from a memory word.
package matvec_pkg;

    typedef enum logic [2:0] {IDLE, REQ, RESP, COMPUTE, DRAIN} state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_K      = 8;
    localparam int DEF_N      = 8;
    localparam int DEF_ACC_W  = 24;
    localparam int MAX_WORD_W = 1024;

    // Element k of a kk-element word of dw-bit elements; element 0 sits in the MS bits.
    function automatic logic [63:0] elem_at(input logic [MAX_WORD_W-1:0] word,
                                            input int k, input int kk, input int dw);
        logic [MAX_WORD_W-1:0] sh;
        sh = word >> ((kk - 1 - k) * dw);
        return sh[63:0] & ((64'd1 << dw) - 64'd1);
    endfunction

endpackage

// File: rtl/matvec_engine_mac_lane.sv
// One unsigned multiply-accumulate lane; one accumulate per enabled cycle, no backpressure.
// MATVEC_SATURATE_EN: clamp at all-ones and raise sat on the clamping cycle; otherwise wrap.
module mac_lane #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  acc
`ifdef MATVEC_SATURATE_EN
    ,
    output logic              sat
`endif
);
    localparam int PW = 2 * DATA_W;

    logic [PW-1:0]    prod;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;

    assign prod = PW'(a) * PW'(b);

`ifdef MATVEC_SATURATE_EN
    localparam int SW = ACC_W + 1;
    logic [ACC_W:0] sum;
    assign sum   = {1'b0, acc_q} + SW'(prod);
    assign acc_d = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
    assign sat   = en & sum[ACC_W];
`else
    assign acc_d = acc_q + ACC_W'(prod);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/matvec_engine.sv
// Fetches B then N A rows (one read outstanding), runs K lockstep MAC cycles over N lanes,
// then drains N results over valid/ready; res_ready low stalls the drain. Optional: MATVEC_SATURATE_EN.
module matvec_engine
    import matvec_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int K      = DEF_K,
    parameter int N      = DEF_N,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W-1:0]     address,
    output logic                  read,
    input  logic [K*DATA_W-1:0]   readdata,
    input  logic                  readdatavalid,
    input  logic                  waitrequest,
    output logic [ACC_W-1:0]      res_data,
    output logic [$clog2(N)-1:0]  res_idx,
    output logic                  res_valid,
    input  logic                  res_ready
`ifdef MATVEC_SATURATE_EN
    ,
    output logic                  sat_flag
`endif
);
    localparam int WORD_W = K * DATA_W;
    localparam int RW     = $clog2(N + 1);
    localparam int JW     = $clog2(N);
    localparam int KW     = (K > 1) ? $clog2(K) : 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [RW-1:0]     r_q, r_d;
    logic [KW-1:0]     k_q, k_d;
    logic [JW-1:0]     j_q, j_d;
    logic              done_q, done_d;
    logic              lane_clr, lane_en, cap_en;

    logic [WORD_W-1:0] b_q;
    logic [WORD_W-1:0] a_q [N];
    logic [DATA_W-1:0] b_k;
    logic [DATA_W-1:0] a_k [N];
    logic [ACC_W-1:0]  acc_w [N];

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        r_d      = r_q;
        k_d      = k_q;
        j_d      = j_q;
        done_d   = 1'b0;
        lane_clr = 1'b0;
        cap_en   = 1'b0;
        unique case (state_q)
            IDLE: if (start) begin
                base_d   = base_addr;
                r_d      = '0;
                lane_clr = 1'b1;
                state_d  = REQ;
            end
            REQ: if (!waitrequest) state_d = RESP;
            RESP: if (readdatavalid) begin
                cap_en = 1'b1;
                r_d    = r_q + 1'b1;
                if (r_q == RW'(N)) begin
                    k_d     = '0;
                    state_d = COMPUTE;
                end else begin
                    state_d = REQ;
                end
            end
            COMPUTE: begin
                k_d = k_q + 1'b1;
                if (k_q == KW'(K - 1)) begin
                    j_d     = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: if (res_ready) begin
                j_d = j_q + 1'b1;
                if (j_q == JW'(N - 1)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            r_q     <= '0;
            k_q     <= '0;
            j_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            r_q     <= r_d;
            k_q     <= k_d;
            j_q     <= j_d;
            done_q  <= done_d;
        end
    end

    // Fetch r=0 is B; fetch r>0 lands in A row r-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_q <= '0;
            for (int i = 0; i < N; i++) a_q[i] <= '0;
        end else if (cap_en) begin
            if (r_q == '0) b_q <= readdata;
            for (int i = 0; i < N; i++) begin
                if (r_q == RW'(i + 1)) a_q[i] <= readdata;
            end
        end
    end

    assign lane_en = (state_q == COMPUTE);
    assign b_k     = DATA_W'(elem_at(MAX_WORD_W'(b_q), int'(k_q), K, DATA_W));

`ifdef MATVEC_SATURATE_EN
    logic [N-1:0] lane_sat;
    logic         sat_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_q <= 1'b0;
        end else if (lane_clr) begin
            sat_q <= 1'b0;
        end else if (|lane_sat) begin
            sat_q <= 1'b1;
        end
    end

    assign sat_flag = sat_q;
`endif

    for (genvar i = 0; i < N; i++) begin : g_lane
        assign a_k[i] = DATA_W'(elem_at(MAX_WORD_W'(a_q[i]), int'(k_q), K, DATA_W));

        mac_lane #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W)
        ) u_lane (
            .clk (clk),
            .rst (rst),
            .clr (lane_clr),
            .en  (lane_en),
            .a   (a_k[i]),
            .b   (b_k),
            .acc (acc_w[i])
`ifdef MATVEC_SATURATE_EN
            ,
            .sat (lane_sat[i])
`endif
        );
    end

    assign busy      = (state_q != IDLE);
    assign read      = (state_q == REQ);
    assign address   = base_q + ADDR_W'(r_q);
    assign res_valid = (state_q == DRAIN);
    assign res_idx   = j_q;
    assign res_data  = acc_w[j_q];
    assign done      = done_q;

endmodule

// File: tb/tb_matvec_engine.sv
// Directed + randomized bench for matvec_engine with a behavioural memory and dot-product model.
module tb_matvec_engine;
    localparam int DW  = 8;
    localparam int K   = 8;
    localparam int N   = 8;
    localparam int AW  = 24;
    localparam int ADW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADW-1:0]    base_addr;
    logic              busy, done, read, readdatavalid, waitrequest;
    logic [ADW-1:0]    address;
    logic [K*DW-1:0]   readdata;
    logic [AW-1:0]     res_data;
    logic [2:0]        res_idx;
    logic              res_valid, res_ready;
`ifdef MATVEC_SATURATE_EN
    logic              sat_flag;
`endif

    always #5 clk = ~clk;

    matvec_engine dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .base_addr     (base_addr),
        .busy          (busy),
        .done          (done),
        .address       (address),
        .read          (read),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .waitrequest   (waitrequest),
        .res_data      (res_data),
        .res_idx       (res_idx),
        .res_valid     (res_valid),
        .res_ready     (res_ready)
`ifdef MATVEC_SATURATE_EN
        ,
        .sat_flag      (sat_flag)
`endif
    );

    logic [K*DW-1:0] mem [0:255];
    logic [DW-1:0]   a_el [N][K];
    logic [DW-1:0]   b_el [K];
    logic [AW-1:0]   exp_res [N];

    int n_total = 0, n_pass = 0, n_fail = 0;

    logic [ADW-1:0] acc_addrs [$];
    bit             pend = 0;
    int             lat = 0;
    logic [ADW-1:0] pend_addr;
    int             nreq = 0;
    bit             rnd_lat = 0;
    int             stall_req = 0, stall_left = 0, stall_seen = 0;
    bit             stall_err = 0;
    logic [ADW-1:0] stall_addr;
    bit             inject_rdv = 0;
    int             done_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Accepted requests are seen on the clock edge, like the memory would see them.
    always @(posedge clk) begin
        if (rst) begin
            pend = 0;
        end else if (read && !waitrequest) begin
            acc_addrs.push_back(address);
            pend_addr = address;
            lat       = rnd_lat ? int'($urandom_range(0, 2)) : 0;
            pend      = 1;
            nreq++;
        end
        if (done) done_cnt++;
    end

    always @(negedge clk) begin
        readdatavalid = 1'b0;
        if (inject_rdv) begin
            readdatavalid = 1'b1;
            readdata      = '1;
            inject_rdv    = 0;
        end else if (pend) begin
            if (lat == 0) begin
                readdatavalid = 1'b1;
                readdata      = mem[pend_addr[7:0]];
                pend          = 0;
            end else begin
                lat--;
            end
        end
        if (stall_left == 0 && stall_req != 0 && read && nreq == stall_req - 1) begin
            stall_left = 5;
            stall_addr = address;
            stall_req  = 0;
        end
        if (stall_left > 0) begin
            waitrequest = 1'b1;
            stall_left--;
            stall_seen++;
            if (!(read && address == stall_addr)) stall_err = 1;
        end else begin
            waitrequest = 1'b0;
        end
    end

    function automatic logic [K*DW-1:0] pack(input logic [DW-1:0] e [K]);
        logic [K*DW-1:0] w;
        w = '0;
        for (int k = 0; k < K; k++) w = (w << DW) | (K*DW)'(e[k]);
        return w;
    endfunction

    // Lay out B and the A rows in memory and compute the expected dot products.
    task automatic load_op(input logic [ADW-1:0] base);
        int unsigned s;
        mem[base[7:0]] = pack(b_el);
        for (int i = 0; i < N; i++) begin
            logic [ADW-1:0] ad;
            ad = base + ADW'(i + 1);
            mem[ad[7:0]] = pack(a_el[i]);
            s = 0;
            for (int k = 0; k < K; k++) s += int'(a_el[i][k]) * int'(b_el[k]);
            exp_res[i] = AW'(s % (1 << AW));
        end
    endtask

    task automatic fill_random();
        for (int k = 0; k < K; k++) b_el[k] = DW'($urandom);
        for (int i = 0; i < N; i++)
            for (int k = 0; k < K; k++) a_el[i][k] = DW'($urandom);
    endtask

    task automatic run_op(input logic [ADW-1:0] base, input int rmode, input string tag);
        int got, cyc;
        bit holding;
        logic [AW-1:0] held_dat;
        logic [2:0] held_idx;
        acc_addrs.delete();
        done_cnt = 0;
        nreq = 0;
        @(negedge clk);
        base_addr = base;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy_start"}, 64'(busy), 64'd1);
        got = 0; cyc = 0; holding = 0;
        while (got < N && cyc < 3000) begin
            start     = (cyc == 5);
            base_addr = (cyc == 5) ? base + 100 : base;
            if (holding && res_valid) begin
                chk($sformatf("%s_hold_dat%0d", tag, got), 64'(res_data), 64'(held_dat));
                chk($sformatf("%s_hold_idx%0d", tag, got), 64'(res_idx), 64'(held_idx));
            end
            case (rmode)
                0: res_ready = 1'b1;
                1: res_ready = (cyc % 3 == 0);
                default: res_ready = 1'($urandom_range(0, 1));
            endcase
            if (res_valid) begin
                if (res_ready) begin
                    chk($sformatf("%s_idx%0d", tag, got), 64'(res_idx), 64'(got));
                    chk($sformatf("%s_dat%0d", tag, got), 64'(res_data), 64'(exp_res[got]));
                    got++;
                    holding = 0;
                end else begin
                    holding  = 1;
                    held_dat = res_data;
                    held_idx = res_idx;
                end
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        res_ready = 1'b0;
        chk({tag, "_result_count"}, 64'(got), 64'(N));
        chk({tag, "_done_pulse"}, 64'(done), 64'd1);
        chk({tag, "_busy_end"}, 64'(busy), 64'd0);
        chk({tag, "_valid_end"}, 64'(res_valid), 64'd0);
        @(negedge clk);
        chk({tag, "_done_low"}, 64'(done), 64'd0);
        chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
        chk({tag, "_nfetch"}, 64'(acc_addrs.size()), 64'(N + 1));
        for (int i = 0; i < acc_addrs.size(); i++)
            chk($sformatf("%s_addr%0d", tag, i), 64'(acc_addrs[i]), 64'(base + ADW'(i)));
`ifdef MATVEC_SATURATE_EN
        chk({tag, "_sat"}, 64'(sat_flag), 64'd0);
`endif
    endtask

    initial begin
        int w;
        rst = 1'b1; start = 1'b0; base_addr = '0; res_ready = 1'b0;
        readdata = '0; readdatavalid = 1'b0; waitrequest = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_read", 64'(read), 64'd0);
        chk("rst_address", 64'(address), 64'd0);
        chk("rst_valid", 64'(res_valid), 64'd0);
        chk("rst_data", 64'(res_data), 64'd0);
        chk("rst_idx", 64'(res_idx), 64'd0);
        rst = 1'b0;

        // Identity A against B = 1..8.
        for (int k = 0; k < K; k++) b_el[k] = DW'(k + 1);
        for (int i = 0; i < N; i++)
            for (int k = 0; k < K; k++) a_el[i][k] = (i == k) ? 8'd1 : 8'd0;
        load_op(0);
        run_op(0, 0, "ident");

        // Every element 0xFF: largest possible sum, still inside 24 bits.
        for (int k = 0; k < K; k++) b_el[k] = 8'hFF;
        for (int i = 0; i < N; i++)
            for (int k = 0; k < K; k++) a_el[i][k] = 8'hFF;
        load_op(40);
        chk("allff_model", 64'(exp_res[0]), 64'd520200);
        run_op(40, 0, "allff");

        // Third request stalled by waitrequest for five cycles.
        fill_random();
        load_op(80);
        stall_seen = 0; stall_err = 0; stall_req = 3;
        run_op(80, 0, "stall");
        chk("stall_cycles", 64'(stall_seen), 64'd5);
        chk("stall_stable", 64'(stall_err), 64'd0);

        // Consumer ready pattern 1,0,0 repeating.
        fill_random();
        load_op(120);
        run_op(120, 1, "toggle");

        // Random data, memory latency and consumer readiness.
        rnd_lat = 1;
        for (int t = 0; t < 3; t++) begin
            logic [ADW-1:0] b;
            b = ADW'($urandom_range(0, 200));
            fill_random();
            load_op(b);
            run_op(b, 2, $sformatf("rand%0d", t));
        end
        rnd_lat = 0;

        // Reset during COMPUTE, stray readdatavalid, then a fresh run at base 16.
        fill_random();
        load_op(200);
        @(negedge clk);
        nreq = 0;
        base_addr = 200;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (!(nreq == N + 1 && !pend) && w < 500) begin
            @(negedge clk);
            w++;
        end
        chk("mid_reach_compute", 64'(w < 500), 64'd1);
        repeat (2) @(negedge clk);
        chk("mid_busy", 64'(busy), 64'd1);
        chk("mid_read", 64'(read), 64'd0);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_read", 64'(read), 64'd0);
        chk("mid_rst_address", 64'(address), 64'd0);
        chk("mid_rst_valid", 64'(res_valid), 64'd0);
        chk("mid_rst_data", 64'(res_data), 64'd0);
        chk("mid_rst_idx", 64'(res_idx), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        inject_rdv = 1;
        repeat (3) @(negedge clk);
        chk("late_rdv_idle", 64'(busy), 64'd0);
        fill_random();
        load_op(16);
        run_op(16, 0, "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
